// File: rtl/mc_seq_ctrl_if.sv
// mc_seq_ctrl_if: signal bundle between the multi-cycle sequencer and its
// surroundings (instruction decoder, datapath, instruction/data memories).
//
// slave  modport: the sequencer itself.
// master modport: the environment driving run/decode/acks and consuming controls.
//
// Signals:
//   run, dec_*, br_taken   decoder/datapath status into the sequencer
//   imem_ack, dmem_ack     memory completion handshakes
//   imem_req, dmem_req,    memory requests (dmem_we qualifies dmem_req)
//   dmem_we
//   ir_we, pc_we, pc_src,  datapath write enables and PC mux select
//   rf_we
//   retire, bus_err,       status: completion pulse, sticky watchdog error,
//   state, cycle_cnt,      current state and free-running counters
//   instr_cnt
interface mc_seq_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run;
    logic             dec_regwrite;
    logic             dec_memread;
    logic             dec_memwrite;
    logic             dec_branch;
    logic             dec_jump;
    logic             br_taken;
    logic             imem_ack;
    logic             dmem_ack;

    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             rf_we;
    logic             retire;
    logic             bus_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport slave (
        input  run, dec_regwrite, dec_memread, dec_memwrite, dec_branch, dec_jump,
               br_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, rf_we, retire,
               bus_err, state, cycle_cnt, instr_cnt
    );

    modport master (
        output run, dec_regwrite, dec_memread, dec_memwrite, dec_branch, dec_jump,
               br_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, rf_we, retire,
               bus_err, state, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle sequencer for the MIPS datapath.
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB using decode strobes
// from the combinational decoder on the latched IR, and drives the datapath
// write enables, PC source select and memory requests. Keeps a cycle counter,
// a retired-instruction counter and an optional wait-state watchdog.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset; all outputs read 0 while asserted
//   bus   mc_seq_ctrl_if.slave: decode/ack inputs, control/status outputs
//
// Parameters:
//   CNT_W       width of cycle_cnt / instr_cnt
//   WAIT_LIMIT  consecutive un-acked wait cycles before bus_err (0 = no watchdog)
module mc_seq_ctrl #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic          clk,
    input  logic          rstn,
    mc_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StErr    = 3'd7
    } state_e;

    // Wait counter only needs to reach WAIT_LIMIT-1; the trip happens on that cycle.
    localparam int unsigned WdW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
    localparam logic WdEn = (WAIT_LIMIT > 0);

    state_e           state_q, state_d;
    logic [WdW-1:0]   wait_q, wait_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    logic             waiting, ack_now, wd_trip;

    logic             imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, rf_we_c;
    logic             retire_c;
    logic [1:0]       pc_src_c;

    // ------------------------------------------------------------------
    // Watchdog: counts consecutive cycles with an outstanding, un-acked request.
    // ------------------------------------------------------------------
    always_comb begin
        waiting = ((state_q == StFetch) && bus.run) || (state_q == StMem);
        ack_now = (state_q == StFetch) ? bus.imem_ack : bus.dmem_ack;
        // An ack on the limit cycle wins over the error.
        wd_trip = WdEn && waiting && !ack_now && (wait_q == WdLast);
        if (WdEn && waiting && !ack_now && !wd_trip) begin
            wait_d = wait_q + WdW'(1);
        end else begin
            wait_d = '0;
        end
        bus_err_d = bus_err_q | wd_trip;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (bus.run && bus.imem_ack) begin
                    state_d = StDecode;
                end else if (wd_trip) begin
                    state_d = StErr;
                end
            end
            StDecode: begin
                state_d = bus.dec_jump ? StFetch : StExec;
            end
            StExec: begin
                if (bus.dec_branch) begin
                    state_d = StFetch;
                end else if (bus.dec_memread || bus.dec_memwrite) begin
                    state_d = StMem;
                end else if (bus.dec_regwrite) begin
                    state_d = StWb;
                end else begin
                    state_d = StFetch;
                end
            end
            StMem: begin
                if (bus.dmem_ack) begin
                    state_d = bus.dec_memread ? StWb : StFetch;
                end else if (wd_trip) begin
                    state_d = StErr;
                end
            end
            StWb:    state_d = StFetch;
            StErr:   state_d = StErr;
            default: state_d = StFetch;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Mealy: state plus current inputs, no added latency)
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_src_c   = 2'b00;
        rf_we_c    = 1'b0;
        retire_c   = 1'b0;
        case (state_q)
            StFetch: begin
                imem_req_c = bus.run;
                if (bus.run && bus.imem_ack) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                end
            end
            StDecode: begin
                if (bus.dec_jump) begin
                    pc_we_c  = 1'b1;
                    pc_src_c = 2'b10;
                    retire_c = 1'b1;
                end
            end
            StExec: begin
                if (bus.dec_branch) begin
                    // Branch target is selected even when not taken; pc_we gates it.
                    pc_we_c  = bus.br_taken;
                    pc_src_c = 2'b01;
                    retire_c = 1'b1;
                end else if (!(bus.dec_memread || bus.dec_memwrite) && !bus.dec_regwrite) begin
                    retire_c = 1'b1;
                end
            end
            StMem: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = bus.dec_memwrite;
                if (bus.dmem_ack && !bus.dec_memread) begin
                    retire_c = 1'b1;
                end
            end
            StWb: begin
                rf_we_c  = 1'b1;
                retire_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs forced low while reset is held, since some depend on live inputs.
    assign bus.imem_req  = rstn & imem_req_c;
    assign bus.dmem_req  = rstn & dmem_req_c;
    assign bus.dmem_we   = rstn & dmem_we_c;
    assign bus.ir_we     = rstn & ir_we_c;
    assign bus.pc_we     = rstn & pc_we_c;
    assign bus.pc_src    = rstn ? pc_src_c : 2'b00;
    assign bus.rf_we     = rstn & rf_we_c;
    assign bus.retire    = rstn & retire_c;
    assign bus.bus_err   = bus_err_q;
    assign bus.state     = state_q;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;

    // ------------------------------------------------------------------
    // Counters (both wrap naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != StErr) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (retire_c) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
